// File: rtl/serial_add_arbiter.sv
// serial_add_arbiter
//   Two requesters share one 1-bit full-adder slice. Each accepted request
//   is a WIDTH-bit unsigned add (carry-in 0), evaluated LSB-first, one bit
//   per clock. Requesters are served round-robin, and the result is held
//   until the consumer takes it.
//
// Ports
//   clk, rst                       clock, async active-high reset
//   reqN_valid/x/y, reqN_ready     operand handshake, N = 0,1
//   res_valid/ready                result handshake
//   res_sum, res_carry, res_id     x+y mod 2^WIDTH, carry out, requester id
//   busy                           high while an operation is in RUN or DONE
module serial_add_arbiter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   input  logic [WIDTH-1:0] req0_x,
   input  logic [WIDTH-1:0] req0_y,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [WIDTH-1:0] req1_x,
   input  logic [WIDTH-1:0] req1_y,
   output logic             req1_ready,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_sum,
   output logic             res_carry,
   output logic             res_id,
   output logic             busy
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic             ptr;      // preferred requester when both are valid
   logic [CW-1:0]    cnt;      // index of the bit processed on the next edge
   logic             carry;
   logic [WIDTH-1:0] sreg;     // sum bits shift in at the MSB, LSB first
   logic [WIDTH-1:0] x_q;
   logic [WIDTH-1:0] y_q;

   logic grant1;
   logic xb, yb, sb, cb;

   // Requester 1 wins if it is alone, or both are valid and it holds priority.
   assign grant1     = req1_valid & (~req0_valid | ptr);
   // Readies are forced low during reset so every output reads 0 while rst is high.
   assign req0_ready = ~rst & (state == IDLE) & req0_valid & ~grant1;
   assign req1_ready = ~rst & (state == IDLE) & grant1;

   // The shared full-adder slice
   assign xb = x_q[cnt];
   assign yb = y_q[cnt];
   assign sb = xb ^ yb ^ carry;
   assign cb = (xb & yb) | (carry & (xb ^ yb));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= 1'b0;
         cnt       <= '0;
         carry     <= 1'b0;
         sreg      <= '0;
         x_q       <= '0;
         y_q       <= '0;
         res_valid <= 1'b0;
         res_sum   <= '0;
         res_carry <= 1'b0;
         res_id    <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req0_ready | req1_ready) begin
                  x_q    <= req1_ready ? req1_x : req0_x;
                  y_q    <= req1_ready ? req1_y : req0_y;
                  res_id <= req1_ready;
                  carry  <= 1'b0;
                  cnt    <= '0;
                  sreg   <= '0;
                  busy   <= 1'b1;
                  state  <= RUN;
               end
            end
            RUN: begin
               sreg  <= {sb, sreg[WIDTH-1:1]};
               carry <= cb;
               cnt   <= cnt + CW'(1);
               if (cnt == CW'(WIDTH-1)) begin
                  // Final bit: the assembled word goes straight to the result.
                  res_sum   <= {sb, sreg[WIDTH-1:1]};
                  res_carry <= cb;
                  res_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (res_ready) begin
                  ptr       <= ~res_id;
                  res_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_add_arbiter.sv
module tb_serial_add_arbiter;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         req0_valid, req1_valid, req0_ready, req1_ready;
   logic [W-1:0] req0_x, req0_y, req1_x, req1_y;
   logic         res_valid, res_ready, res_carry, res_id, busy;
   logic [W-1:0] res_sum;

   int errors = 0;
   int checks = 0;

   serial_add_arbiter #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_x(req0_x), .req0_y(req0_y), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_x(req1_x), .req1_y(req1_y), .req1_ready(req1_ready),
      .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
      .res_carry(res_carry), .res_id(res_id), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one request with res_ready=1 and reports what was observed.
   task automatic do_op(input bit id, input logic [W-1:0] x, input logic [W-1:0] y,
                        output int wcnt, output int lat, output logic [W-1:0] s,
                        output logic c, output logic rid, output int bcnt);
      wcnt = 0; lat = -1; bcnt = 0; s = '0; c = 1'b0; rid = 1'b0;
      res_ready = 1'b1;
      if (id) begin req1_valid = 1'b1; req1_x = x; req1_y = y; end
      else    begin req0_valid = 1'b1; req0_x = x; req0_y = y; end
      #1;
      while (wcnt < 40 && !(id ? req1_ready : req0_ready)) begin
         tick();
         wcnt++;
      end
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      for (int n = 1; n <= 40; n++) begin
         if (busy) bcnt++;
         if (res_valid && lat < 0) begin
            lat = n; s = res_sum; c = res_carry; rid = res_id;
         end
         if (!busy && lat >= 0) break;
         tick();
      end
   endtask

   task automatic wait_idle();
      for (int k = 0; k < 40 && busy; k++) tick();
   endtask

   task automatic test_reset();
      rst = 1'b1; res_ready = 1'b1;
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_x = 8'h11; req0_y = 8'h22; req1_x = 8'h33; req1_y = 8'h44;
      tick(); tick();
      checks++;
      if ({res_valid, res_sum, res_carry, res_id, busy, req0_ready, req1_ready} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got v=%b s=%h c=%b id=%b busy=%b r0=%b r1=%b exp all 0",
                  res_valid, res_sum, res_carry, res_id, busy, req0_ready, req1_ready);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      rst = 1'b0;
      #1;
      checks++;
      if ({res_valid, busy} !== 2'b00) begin
         errors++;
         $display("FAIL reset_release got v=%b busy=%b exp 0 0", res_valid, busy);
      end
   endtask

   task automatic test_basic();
      int wcnt, lat, bcnt; logic [W-1:0] s; logic c, rid;
      do_op(1'b0, 8'h03, 8'h05, wcnt, lat, s, c, rid, bcnt);
      checks++;
      if (wcnt != 0) begin errors++; $display("FAIL basic_ready_wait got=%0d exp=0", wcnt); end
      checks++;
      if (lat != W + 1) begin errors++; $display("FAIL basic_latency got=%0d exp=%0d", lat, W + 1); end
      checks++;
      if ({s, c, rid} !== {8'h08, 1'b0, 1'b0}) begin
         errors++; $display("FAIL basic_result got s=%h c=%b id=%b exp s=08 c=0 id=0", s, c, rid);
      end
      checks++;
      if (bcnt != W + 1) begin errors++; $display("FAIL basic_busy_cycles got=%0d exp=%0d", bcnt, W + 1); end
   endtask

   task automatic test_arith();
      int wcnt, lat, bcnt; logic [W-1:0] s; logic c, rid;
      do_op(1'b1, 8'hFF, 8'h01, wcnt, lat, s, c, rid, bcnt);
      checks++;
      if ({s, c, rid} !== {8'h00, 1'b1, 1'b1}) begin
         errors++; $display("FAIL arith_ff_01 got s=%h c=%b id=%b exp s=00 c=1 id=1", s, c, rid);
      end
      do_op(1'b1, 8'd200, 8'd100, wcnt, lat, s, c, rid, bcnt);
      checks++;
      if ({s, c, rid} !== {8'h2C, 1'b1, 1'b1}) begin
         errors++; $display("FAIL arith_200_100 got s=%h c=%b id=%b exp s=2c c=1 id=1", s, c, rid);
      end
   endtask

   task automatic test_fair();
      int nacc = 0; int at[4]; logic ids[4]; bit both = 0;
      res_ready = 1'b1;
      for (int cyc = 0; cyc < 80 && nacc < 4; cyc++) begin
         req0_valid = 1'b1; req1_valid = 1'b1;
         req0_x = W'($urandom); req0_y = W'($urandom);
         req1_x = W'($urandom); req1_y = W'($urandom);
         #1;
         if (req0_ready && req1_ready) both = 1;
         if (req0_ready || req1_ready) begin
            ids[nacc] = req1_ready; at[nacc] = cyc; nacc++;
         end
         tick();
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      wait_idle();
      checks++;
      if (both) begin errors++; $display("FAIL fair_exclusive got both readies high exp never"); end
      checks++;
      if (nacc != 4) begin
         errors++; $display("FAIL fair_count got=%0d exp=4", nacc);
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (ids[i] !== 1'(i % 2)) begin
               errors++; $display("FAIL fair_order[%0d] got=%b exp=%0d", i, ids[i], i % 2);
            end
         end
         for (int i = 1; i < 4; i++) begin
            checks++;
            if (at[i] - at[i-1] != W + 2) begin
               errors++; $display("FAIL fair_spacing[%0d] got=%0d exp=%0d", i, at[i] - at[i-1], W + 2);
            end
         end
      end
   endtask

   task automatic test_hold();
      int k; bit bad = 0;
      res_ready = 1'b0;
      req0_valid = 1'b1; req0_x = 8'h21; req0_y = 8'h34;
      #1;
      for (k = 0; k < 40 && !req0_ready; k++) tick();
      tick();
      req0_x = 8'h77; req0_y = 8'h01;   // next request stays pending
      for (k = 0; k < 40 && !res_valid; k++) tick();
      for (int i = 0; i < 5; i++) begin
         if (!res_valid || res_sum !== 8'h55 || res_carry !== 1'b0 || req0_ready !== 1'b0) begin
            bad = 1;
            $display("FAIL hold_cycle%0d got v=%b s=%h c=%b r0=%b exp v=1 s=55 c=0 r0=0",
                     i, res_valid, res_sum, res_carry, req0_ready);
         end
         tick();
      end
      checks++;
      if (bad) errors++;
      res_ready = 1'b1;
      #1;
      checks++;
      if (req0_ready !== 1'b0) begin errors++; $display("FAIL hold_handshake_ready got=%b exp=0", req0_ready); end
      tick();
      checks++;
      if ({res_valid, busy, req0_ready, res_sum} !== {1'b0, 1'b0, 1'b1, 8'h55}) begin
         errors++;
         $display("FAIL hold_idle got v=%b busy=%b r0=%b s=%h exp v=0 busy=0 r0=1 s=55",
                  res_valid, busy, req0_ready, res_sum);
      end
      tick();
      req0_valid = 1'b0;
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL hold_next_accept busy got=%b exp=1", busy); end
      for (k = 0; k < 40 && !res_valid; k++) tick();
      checks++;
      if ({res_valid, res_sum} !== {1'b1, 8'h78}) begin
         errors++; $display("FAIL hold_next_result got v=%b s=%h exp v=1 s=78", res_valid, res_sum);
      end
      wait_idle();
   endtask

   task automatic test_change();
      int k;
      res_ready = 1'b1;
      req0_valid = 1'b1; req0_x = 8'h10; req0_y = 8'h01;
      #1;
      for (k = 0; k < 40 && !req0_ready; k++) tick();
      tick();
      req0_valid = 1'b0; req0_x = 8'hAA;
      for (k = 0; k < 40 && !res_valid; k++) tick();
      checks++;
      if ({res_valid, res_sum, res_carry} !== {1'b1, 8'h11, 1'b0}) begin
         errors++; $display("FAIL change_operand got v=%b s=%h c=%b exp v=1 s=11 c=0",
                            res_valid, res_sum, res_carry);
      end
      wait_idle();
   endtask

   task automatic test_rst_mid();
      int wcnt, lat, bcnt, k; logic [W-1:0] s; logic c, rid; bit seen = 0;
      do_op(1'b0, 8'h01, 8'h01, wcnt, lat, s, c, rid, bcnt);   // leaves priority on requester 1
      res_ready = 1'b1;
      req0_valid = 1'b1; req0_x = 8'h0F; req0_y = 8'h0F;
      req1_valid = 1'b1; req1_x = 8'h40; req1_y = 8'h40;
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== 2'b01) begin
         errors++; $display("FAIL rstmid_pre_grant got r0=%b r1=%b exp r0=0 r1=1", req0_ready, req1_ready);
      end
      tick();
      for (int i = 0; i < 4; i++) tick();
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({res_valid, res_sum, res_carry, res_id, busy, req0_ready, req1_ready} !== '0) begin
         errors++;
         $display("FAIL rstmid_outputs got v=%b s=%h c=%b id=%b busy=%b r0=%b r1=%b exp all 0",
                  res_valid, res_sum, res_carry, res_id, busy, req0_ready, req1_ready);
      end
      tick();
      rst = 1'b0;
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         errors++; $display("FAIL rstmid_post_grant got r0=%b r1=%b exp r0=1 r1=0", req0_ready, req1_ready);
      end
      tick();
      for (int i = 0; i < W - 1; i++) begin
         if (res_valid) seen = 1;
         tick();
      end
      checks++;
      if (seen) begin errors++; $display("FAIL rstmid_aborted got res_valid=1 exp no result"); end
      req0_valid = 1'b0; req1_valid = 1'b0;
      for (k = 0; k < 40 && !res_valid; k++) tick();
      checks++;
      if ({res_valid, res_sum, res_id} !== {1'b1, 8'h1E, 1'b0}) begin
         errors++; $display("FAIL rstmid_first_result got v=%b s=%h id=%b exp v=1 s=1e id=0",
                            res_valid, res_sum, res_id);
      end
      wait_idle();
   endtask

   // Random traffic against a transaction-level model: an accepted add
   // produces its result WIDTH+1 cycles later and waits for the consumer.
   task automatic test_random();
      int m_cnt = 0; bit m_done = 0; bit m_ptr = 0;
      logic [W-1:0] m_sum = '0; logic m_carry = 0; logic m_id = 0;
      logic [W:0] pend = '0;
      bit e0, e1, m_idle;
      logic v0, v1, rr;
      logic [W-1:0] x0, y0, x1, y1;
      int nerr = 0;
      rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
      tick();
      rst = 1'b0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         v0 = 1'($urandom_range(0, 1)); v1 = 1'($urandom_range(0, 1));
         rr = ($urandom_range(0, 3) != 0);
         x0 = W'($urandom); y0 = W'($urandom); x1 = W'($urandom); y1 = W'($urandom);
         req0_valid = v0; req0_x = x0; req0_y = y0;
         req1_valid = v1; req1_x = x1; req1_y = y1;
         res_ready = rr;
         #1;
         m_idle = (m_cnt == 0) && !m_done;
         e0 = m_idle && v0 && (!v1 || !m_ptr);
         e1 = m_idle && v1 && (!v0 || m_ptr);
         checks++;
         if ({req0_ready, req1_ready, res_valid, busy} !== {e0, e1, m_done, !m_idle}) begin
            errors++;
            if (nerr++ < 10)
               $display("FAIL rand_ctrl cyc%0d got r0=%b r1=%b v=%b busy=%b exp r0=%b r1=%b v=%b busy=%b",
                        cyc, req0_ready, req1_ready, res_valid, busy, e0, e1, m_done, !m_idle);
         end
         checks++;
         if ({res_sum, res_carry, res_id} !== {m_sum, m_carry, m_id}) begin
            errors++;
            if (nerr++ < 10)
               $display("FAIL rand_result cyc%0d got s=%h c=%b id=%b exp s=%h c=%b id=%b",
                        cyc, res_sum, res_carry, res_id, m_sum, m_carry, m_id);
         end
         if (m_done) begin
            if (rr) begin m_done = 0; m_ptr = !m_id; end
         end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin m_done = 1; m_sum = pend[W-1:0]; m_carry = pend[W]; end
         end else if (e0 || e1) begin
            m_cnt = W;
            m_id  = e1;
            pend  = e1 ? ({1'b0, x1} + {1'b0, y1}) : ({1'b0, x0} + {1'b0, y0});
         end
         tick();
      end
      req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b1;
      wait_idle();
   endtask

   initial begin
      rst = 1'b1; res_ready = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_x = '0; req0_y = '0; req1_x = '0; req1_y = '0;
      test_reset();
      test_basic();
      test_arith();
      test_fair();
      test_hold();
      test_change();
      test_rst_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
